gamepad_scan: RTL and testbench
===============================

GAMEPAD_SCAN -- requirements
Module: gamepad_scan

Interface
REQ-001 SHALL have parameter SEL_WIDTH, default 1: width of the pad select lines.
REQ-002 SHALL have parameter DATA_WIDTH, default 2: number of parallel data lanes.
REQ-003 SHALL have parameter REG_WIDTH, default 12: bits per pad.
REQ-004 SHALL have parameter PERIOD, default 250000: clk cycles between scan starts.
REQ-005 SHALL have parameter TIMEOUT, default 4096: maximum clk cycles to wait on one pad.
REQ-006 SHALL have derived constants N = DATA_WIDTH<<SEL_WIDTH pads, and ML = clog2(DATA_WIDTH), or 1 when DATA_WIDTH=1.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port ctrl_go  out  1  one-cycle start pulse to the serial reader.
REQ-010 SHALL have port ctrl_sel  out  SEL_WIDTH  select group for the current pad.
REQ-011 SHALL have port ctrl_mux  out  ML  data lane for the current pad.
REQ-012 SHALL have port ctrl_rdy  in  1  reader idle, gp_value valid.
REQ-013 SHALL have port gp_value  in  REG_WIDTH  shifted value of the selected pad.
REQ-014 SHALL have port cfg_en  in  1  enable periodic scanning.
REQ-015 SHALL have port press_clr  in  N  write-1-to-clear of press_flag bits.
REQ-016 SHALL have port pad_state  out  N*REG_WIDTH  last good value per pad; pad i occupies bits [i*REG_WIDTH +: REG_WIDTH].
REQ-017 SHALL have port press_flag  out  N  sticky: pad saw a new button press.
REQ-018 SHALL have port pad_err  out  N  last read of the pad timed out.
REQ-019 SHALL have port scan_done  out  1  one-cycle pulse at the end of each full scan.
REQ-020 SHALL have port irq  out  1  equals OR of press_flag.

Function
REQ-021 Period counter SHALL count 0..PERIOD-1 and wrap, emitting a tick at the wrap; it SHALL run only while cfg_en=1 and SHALL hold at 0 while cfg_en=0.
REQ-022 FSM states SHALL be IDLE, ISSUE, SETTLE, WAIT, STORE.
REQ-023 IDLE->ISSUE SHALL occur on tick when ctrl_rdy=1, with pad index p=0; a tick arriving while not in IDLE SHALL be dropped.
REQ-024 In ISSUE, ctrl_go SHALL be 1 for exactly one cycle, and ctrl_sel=p>>ML, ctrl_mux=p[ML-1:0] (ctrl_mux=0 when DATA_WIDTH=1); ISSUE->SETTLE unconditionally.
REQ-025 ctrl_sel and ctrl_mux SHALL hold stable from ISSUE until STORE completes.
REQ-026 SETTLE SHALL last exactly 1 cycle and SHALL ignore ctrl_rdy; SETTLE->WAIT.
REQ-027 WAIT->STORE SHALL occur on ctrl_rdy=1; a timeout counter SHALL be cleared in ISSUE, and if it reaches TIMEOUT cycles in WAIT the FSM SHALL go to STORE with the timeout flag set.
REQ-028 STORE without timeout SHALL write gp_value to pad_state[p], clear pad_err[p], and set press_flag[p] if any bit goes 0->1 versus the previous pad_state[p].
REQ-029 STORE with timeout SHALL set pad_err[p] and leave pad_state[p] and press_flag[p] unchanged.
REQ-030 After STORE: if p<N-1, p SHALL increment and the FSM SHALL go to ISSUE; otherwise scan_done SHALL pulse and the FSM SHALL go to IDLE.
REQ-031 cfg_en falling mid-scan SHALL NOT abort the scan; the current scan SHALL complete, then the FSM SHALL stay in IDLE.
REQ-032 When a press_clr[i]=1 and a set of press_flag[i] occur in the same cycle, set SHALL win.
REQ-033 irq SHALL be registered, and SHALL assert 1 cycle after press_flag goes nonzero.
REQ-034 Scan latency SHALL be N*(3+rd) cycles, plus 1 for each wait state, where rd is the reader busy time.

Reset
REQ-035 rst_n low SHALL asynchronously force FSM=IDLE, p=0, all counters=0, ctrl_go=0, ctrl_sel=0, ctrl_mux=0, pad_state=all 0, press_flag=0, pad_err=0, scan_done=0, irq=0.
REQ-036 Reset asserted mid-scan SHALL discard the scan; the first tick after release SHALL occur PERIOD cycles after cfg_en=1 is seen.

Structure
REQ-037 FSM state encoding and default parameter values SHALL live in the shared package gamepad_pkg.
REQ-038 The period/timeout tick generation SHALL be a single sub-module, gamepad_scan_timer; the per-pad storage SHALL be inline.

Verification
REQ-039 Bench SHALL cover: N=4, reader model rdy low 200 cycles, values 0x001/0x002/0x004/0x008 -> pad_state matches, exactly 4 ctrl_go pulses with sel/mux (0,0)(0,1)(1,0)(1,1), one scan_done.
REQ-040 Bench SHALL cover: second scan where pad 2 goes 0x004->0x00C -> press_flag=0b0100, irq=1 next cycle; pad 2 0x00C->0x004 alone -> no flag.
REQ-041 Bench SHALL cover: press_clr=0b0100 in the same cycle as a new pad-2 press -> flag remains 1; press_clr on a later cycle -> flag 0, irq 0.
REQ-042 Bench SHALL cover: reader never raises rdy for pad 1 -> pad_err=0b0010 after TIMEOUT cycles, pad_state[1] unchanged, scan continues to pad 3.
REQ-043 Bench SHALL cover: rst_n low during WAIT of pad 2 -> all outputs zero immediately; no ctrl_go until PERIOD cycles after release.
REQ-044 Bench SHALL cover: cfg_en dropped during pad 1 -> scan completes with scan_done, then no further ctrl_go.

Source files
------------

// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared scan FSM encoding, default parameters and width helper
package gamepad_pkg;

    localparam int GP_SEL_WIDTH  = 1;
    localparam int GP_DATA_WIDTH = 2;
    localparam int GP_REG_WIDTH  = 12;
    localparam int GP_PERIOD     = 250000;
    localparam int GP_TIMEOUT    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_STORE
    } scan_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int gp_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/gamepad_scan_timer.sv
// rtl/gamepad_scan_timer.sv - scan period tick and per-pad reader timeout
module gamepad_scan_timer
    import gamepad_pkg::*;
#(
    parameter int PERIOD  = GP_PERIOD,
    parameter int TIMEOUT = GP_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic to_clr_i,
    input  logic to_run_i,
    output logic tick_o,
    output logic to_hit_o
);

    localparam int PCW = gp_width(PERIOD);
    localparam int TCW = gp_width(TIMEOUT);

    logic [PCW-1:0] period_q, period_d;
    logic [TCW-1:0] to_q, to_d;

    assign tick_o   = en_i && (period_q == PCW'(PERIOD - 1));
    assign to_hit_o = (to_q == TCW'(TIMEOUT - 1));

    // Period counter wraps at PERIOD-1 and parks at 0 while scanning is disabled;
    // timeout counter restarts on each issue and saturates on the hit value.
    always_comb begin
        period_d = period_q;
        to_d     = to_q;
        if (!en_i) begin
            period_d = '0;
        end else if (period_q == PCW'(PERIOD - 1)) begin
            period_d = '0;
        end else begin
            period_d = period_q + PCW'(1);
        end
        if (to_clr_i) begin
            to_d = '0;
        end else if (to_run_i && !to_hit_o) begin
            to_d = to_q + TCW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            to_q     <= '0;
        end else begin
            period_q <= period_d;
            to_q     <= to_d;
        end
    end

endmodule

// File: rtl/gamepad_scan.sv
// rtl/gamepad_scan.sv - periodic multi-pad scanner driving a serial gamepad reader
module gamepad_scan
    import gamepad_pkg::*;
#(
    parameter int SEL_WIDTH  = GP_SEL_WIDTH,
    parameter int DATA_WIDTH = GP_DATA_WIDTH,
    parameter int REG_WIDTH  = GP_REG_WIDTH,
    parameter int PERIOD     = GP_PERIOD,
    parameter int TIMEOUT    = GP_TIMEOUT,
    localparam int N         = DATA_WIDTH << SEL_WIDTH,
    localparam int ML        = gp_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ctrl_go,
    output logic [SEL_WIDTH-1:0]   ctrl_sel,
    output logic [ML-1:0]          ctrl_mux,
    input  logic                   ctrl_rdy,
    input  logic [REG_WIDTH-1:0]   gp_value,
    input  logic                   cfg_en,
    input  logic [N-1:0]           press_clr,
    output logic [N*REG_WIDTH-1:0] pad_state,
    output logic [N-1:0]           press_flag,
    output logic [N-1:0]           pad_err,
    output logic                   scan_done,
    output logic                   irq
);

    localparam int PW = gp_width(N);
    // With a single lane every pad index is a select group, so nothing is shifted out.
    localparam int MS = (DATA_WIDTH > 1) ? ML : 0;

    scan_state_e            state_q, state_d;
    logic [PW-1:0]          p_q, p_d;
    logic                   to_flag_q, to_flag_d;
    logic [N*REG_WIDTH-1:0] pad_state_q, pad_state_d;
    logic [N-1:0]           press_flag_q, press_flag_d;
    logic [N-1:0]           pad_err_q, pad_err_d;
    logic [N-1:0]           set_vec;
    logic                   irq_q;
    logic                   tick;
    logic                   to_hit;

    gamepad_scan_timer #(
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (cfg_en),
        .to_clr_i (state_q == ST_ISSUE),
        .to_run_i (state_q == ST_WAIT),
        .tick_o   (tick),
        .to_hit_o (to_hit)
    );

    assign ctrl_go    = (state_q == ST_ISSUE);
    assign ctrl_sel   = SEL_WIDTH'(p_q >> MS);
    assign scan_done  = (state_q == ST_STORE) && (p_q == PW'(N - 1));
    assign pad_state  = pad_state_q;
    assign press_flag = press_flag_q;
    assign pad_err    = pad_err_q;
    assign irq        = irq_q;

    generate
        if (DATA_WIDTH > 1) begin : g_mux
            assign ctrl_mux = ML'(p_q);
        end else begin : g_nomux
            assign ctrl_mux = '0;
        end
    endgenerate

    // Scan sequencer: walk every pad through issue, settle, wait and store.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        to_flag_d = to_flag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick && ctrl_rdy) begin
                    state_d = ST_ISSUE;
                    p_d     = '0;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_SETTLE;
                to_flag_d = 1'b0;
            end
            ST_SETTLE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl_rdy) begin
                    state_d   = ST_STORE;
                    to_flag_d = 1'b0;
                end else if (to_hit) begin
                    state_d   = ST_STORE;
                    to_flag_d = 1'b1;
                end
            end
            ST_STORE: begin
                if (p_q == PW'(N - 1)) begin
                    state_d = ST_IDLE;
                    p_d     = '0;
                end else begin
                    state_d = ST_ISSUE;
                    p_d     = p_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-pad storage: capture the value or record a timeout; new presses beat a clear.
    always_comb begin
        pad_state_d = pad_state_q;
        pad_err_d   = pad_err_q;
        set_vec     = '0;
        if (state_q == ST_STORE) begin
            for (int i = 0; i < N; i++) begin
                if (p_q == PW'(i)) begin
                    if (to_flag_q) begin
                        pad_err_d[i] = 1'b1;
                    end else begin
                        pad_state_d[i*REG_WIDTH +: REG_WIDTH] = gp_value;
                        pad_err_d[i] = 1'b0;
                        set_vec[i]   = |(gp_value & ~pad_state_q[i*REG_WIDTH +: REG_WIDTH]);
                    end
                end
            end
        end
        press_flag_d = (press_flag_q & ~press_clr) | set_vec;
    end

    // State, pad index and storage registers; irq trails the flags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            to_flag_q    <= 1'b0;
            pad_state_q  <= '0;
            press_flag_q <= '0;
            pad_err_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            to_flag_q    <= to_flag_d;
            pad_state_q  <= pad_state_d;
            press_flag_q <= press_flag_d;
            pad_err_q    <= pad_err_d;
            irq_q        <= |press_flag_q;
        end
    end

endmodule

// File: tb/tb_gamepad_scan.sv
// tb/tb_gamepad_scan.sv - directed bench for gamepad_scan with a simple reader model
module tb_gamepad_scan;

    localparam int PERIOD  = 1000;
    localparam int TIMEOUT = 300;
    localparam int RD      = 200;
    localparam int BUDGET  = PERIOD + 4 * (TIMEOUT + 10) + 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_go;
    logic [0:0]  ctrl_sel;
    logic [0:0]  ctrl_mux;
    logic        ctrl_rdy;
    logic [11:0] gp_value;
    logic        cfg_en;
    logic [3:0]  press_clr;
    logic [47:0] pad_state;
    logic [3:0]  press_flag;
    logic [3:0]  pad_err;
    logic        scan_done;
    logic        irq;

    gamepad_scan #(
        .SEL_WIDTH  (1),
        .DATA_WIDTH (2),
        .REG_WIDTH  (12),
        .PERIOD     (PERIOD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_go    (ctrl_go),
        .ctrl_sel   (ctrl_sel),
        .ctrl_mux   (ctrl_mux),
        .ctrl_rdy   (ctrl_rdy),
        .gp_value   (gp_value),
        .cfg_en     (cfg_en),
        .press_clr  (press_clr),
        .pad_state  (pad_state),
        .press_flag (press_flag),
        .pad_err    (pad_err),
        .scan_done  (scan_done),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pre_clr;
        logic [47:0] vals;
        int          hang;
        int          clr_pad;
        logic [47:0] exp_state;
        logic [3:0]  exp_flag;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t        tbl [6];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          go_cnt = 0;
    int          done_cnt = 0;
    int          go_sm [64];
    int          busy = 0;
    int          cur = 0;
    int          arm = 0;
    int          hang_pad = -1;
    int          clr_pad = -1;
    int          t_flag = -1;
    int          t_irq = -1;
    logic [47:0] vals_cur = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_done(input string name, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic wait_go(input string name, input int target);
        int k = 0;
        while (go_cnt < target && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(go_cnt >= target), 64'd1);
    endtask

    // Reader model: busy for RD cycles after each go, then presents the pad value.
    always @(negedge clk) begin
        cyc++;
        if (scan_done) done_cnt++;
        if (t_flag < 0 && press_flag != 4'h0) t_flag = cyc;
        if (t_irq < 0 && irq) t_irq = cyc;
        if (!rst_n) begin
            ctrl_rdy = 1'b1;
            busy     = 0;
            arm      = 0;
        end else begin
            if (arm == 2) begin
                press_clr = 4'h0;
                arm       = 0;
            end
            if (arm == 1) begin
                press_clr = 4'(1 << cur);
                arm       = 2;
            end
            if (ctrl_go) begin
                go_sm[go_cnt & 63] = int'({ctrl_sel, ctrl_mux});
                go_cnt++;
                cur      = int'({ctrl_sel, ctrl_mux});
                ctrl_rdy = 1'b0;
                busy     = RD;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0 && cur != hang_pad) begin
                    gp_value = vals_cur[cur*12 +: 12];
                    ctrl_rdy = 1'b1;
                    if (cur == clr_pad) arm = 1;
                end
            end
        end
    end

    initial begin
        logic [3:0] prev_flag;
        int         go0;
        int         done0;
        logic       early;

        tbl[0] = '{4'hF, 48'h008_004_002_001, -1, -1, 48'h008_004_002_001, 4'hF, 4'h0};
        tbl[1] = '{4'hF, 48'h008_00C_002_001, -1, -1, 48'h008_00C_002_001, 4'h4, 4'h0};
        tbl[2] = '{4'hF, 48'h008_004_002_001, -1, -1, 48'h008_004_002_001, 4'h0, 4'h0};
        tbl[3] = '{4'hF, 48'h008_00C_002_001, -1,  2, 48'h008_00C_002_001, 4'h4, 4'h0};
        tbl[4] = '{4'h4, 48'h018_004_009_001,  1, -1, 48'h018_004_002_001, 4'h8, 4'h2};
        tbl[5] = '{4'hF, 48'h018_004_003_001, -1, -1, 48'h018_004_003_001, 4'h2, 4'h0};

        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        press_clr = 4'h0;
        ctrl_rdy  = 1'b1;
        gp_value  = 12'h0;
        repeat (3) @(negedge clk);
        chk("rst_go",    64'(ctrl_go),    64'd0);
        chk("rst_sel",   64'(ctrl_sel),   64'd0);
        chk("rst_mux",   64'(ctrl_mux),   64'd0);
        chk("rst_state", 64'(pad_state),  64'd0);
        chk("rst_flag",  64'(press_flag), 64'd0);
        chk("rst_err",   64'(pad_err),    64'd0);
        chk("rst_done",  64'(scan_done),  64'd0);
        chk("rst_irq",   64'(irq),        64'd0);
        rst_n = 1'b1;
        prev_flag = 4'h0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            press_clr = tbl[i].pre_clr;
            @(negedge clk);
            press_clr = 4'h0;
            repeat (2) @(negedge clk);
            chk($sformatf("s%0d_preclr_flag", i), 64'(press_flag), 64'(prev_flag & ~tbl[i].pre_clr));
            chk($sformatf("s%0d_preclr_irq", i), 64'(irq), 64'(|(prev_flag & ~tbl[i].pre_clr)));

            vals_cur = tbl[i].vals;
            hang_pad = tbl[i].hang;
            clr_pad  = tbl[i].clr_pad;
            go0      = go_cnt;
            done0    = done_cnt;
            t_flag   = -1;
            t_irq    = -1;
            cfg_en   = 1'b1;
            wait_done($sformatf("s%0d_scan_done_wait", i), done0);
            cfg_en = 1'b0;
            repeat (3) @(negedge clk);

            chk($sformatf("s%0d_pad_state", i), 64'(pad_state), 64'(tbl[i].exp_state));
            chk($sformatf("s%0d_press_flag", i), 64'(press_flag), 64'(tbl[i].exp_flag));
            chk($sformatf("s%0d_pad_err", i), 64'(pad_err), 64'(tbl[i].exp_err));
            chk($sformatf("s%0d_go_count", i), 64'(go_cnt - go0), 64'd4);
            chk($sformatf("s%0d_done_count", i), 64'(done_cnt - done0), 64'd1);
            chk($sformatf("s%0d_irq", i), 64'(irq), 64'(tbl[i].exp_flag != 4'h0));
            if (tbl[i].exp_flag != 4'h0)
                chk($sformatf("s%0d_irq_lag", i), 64'(t_irq - t_flag), 64'd1);
            if (i == 0) begin
                for (int j = 0; j < 4; j++)
                    chk($sformatf("s0_selmux_%0d", j), 64'(go_sm[(go0 + j) & 63]), 64'(j));
            end
            prev_flag = tbl[i].exp_flag;
            hang_pad  = -1;
            clr_pad   = -1;
        end

        // cfg_en dropped while pad 1 is in flight: scan finishes, nothing restarts.
        go0    = go_cnt;
        done0  = done_cnt;
        cfg_en = 1'b1;
        wait_go("drop_go_wait", go0 + 2);
        cfg_en = 1'b0;
        wait_done("drop_scan_done_wait", done0);
        repeat (2 * PERIOD) @(negedge clk);
        chk("drop_go_count", 64'(go_cnt - go0), 64'd4);
        chk("drop_done_count", 64'(done_cnt - done0), 64'd1);

        // Reset during WAIT of pad 2, then the restart delay after release.
        vals_cur = 48'h0FF_0FF_0FF_0FF;
        go0      = go_cnt;
        cfg_en   = 1'b1;
        wait_go("rst_go_wait", go0 + 3);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_go",    64'(ctrl_go),    64'd0);
        chk("midrst_sel",   64'(ctrl_sel),   64'd0);
        chk("midrst_mux",   64'(ctrl_mux),   64'd0);
        chk("midrst_state", 64'(pad_state),  64'd0);
        chk("midrst_flag",  64'(press_flag), 64'd0);
        chk("midrst_err",   64'(pad_err),    64'd0);
        chk("midrst_done",  64'(scan_done),  64'd0);
        chk("midrst_irq",   64'(irq),        64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (k < PERIOD && ctrl_go) early = 1'b1;
            if (k == PERIOD) chk("go_after_release", 64'(ctrl_go), 64'd1);
        end
        chk("no_early_go", 64'(early), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
